// File: rtl/piradip_ram_stream_reader.sv
// Playback engine: reads a block of words from a RAM port and emits them as an AXI-Stream.
// Define PIRADIP_RAM_READER_LOOP_EN to add the loop input for continuous repeated passes.
module piradip_ram_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] length,
`ifdef PIRADIP_RAM_READER_LOOP_EN
  input  logic                  loop,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FD = 1 << PW;
  localparam int CW = $clog2(FD + READ_LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;
  state_t state;

  logic [ADDR_WIDTH:0]     remaining;
  logic [ADDR_WIDTH:0]     len_words;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           fifo_count;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [DATA_WIDTH:0]     fifo_mem [FD];
  logic [DATA_WIDTH:0]     head;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    credit_ok;
  logic                    last_issue;
  logic                    repeat_pass;
  logic                    push;
  logic                    pop;
  logic                    flush;

`ifdef PIRADIP_RAM_READER_LOOP_EN
  logic                  loop_r;
  logic [ADDR_WIDTH-1:0] pass_addr;
  logic [ADDR_WIDTH:0]   pass_len;
  assign repeat_pass = loop_r;
`else
  assign repeat_pass = 1'b0;
`endif

  // A zero length means the whole memory.
  assign len_words = (length == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, length};

  // Every issued read owns a FIFO slot until it is popped, so the FIFO cannot overflow.
  assign credit_ok  = (outstanding + fifo_count) < CW'(FIFO_DEPTH);
  assign ram_en     = (state == RUN) && !stop && (remaining != '0) && credit_ok;
  assign last_issue = ram_en && (remaining == (ADDR_WIDTH+1)'(1));
  assign ram_we     = 1'b0;
  assign ram_wdata  = '0;

  assign flush = stop && (state != IDLE);
  assign push  = pipe_vld[READ_LATENCY-1] && (state != FLUSH) && !stop;
  assign pop   = m_axis_tvalid && m_axis_tready;

  assign head          = fifo_mem[rd_ptr];
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid && head[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
`ifdef PIRADIP_RAM_READER_LOOP_EN
      loop_r    <= 1'b0;
      pass_addr <= '0;
      pass_len  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (ram_en) begin
        ram_addr  <= ram_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
`ifdef PIRADIP_RAM_READER_LOOP_EN
        if (last_issue && loop_r) begin
          ram_addr  <= pass_addr;
          remaining <= pass_len;
        end
`endif
      end
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= RUN;
            busy      <= 1'b1;
            ram_addr  <= start_addr;
            remaining <= len_words;
`ifdef PIRADIP_RAM_READER_LOOP_EN
            loop_r    <= loop;
            pass_addr <= start_addr;
            pass_len  <= len_words;
`endif
          end
        end
        RUN: begin
          if (stop) state <= FLUSH;
          else if (last_issue && !repeat_pass) state <= DRAIN;
        end
        DRAIN: begin
          if (stop) state <= FLUSH;
          else if (pop && m_axis_tlast) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          if (outstanding == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return pipeline mirrors the RAM latency; data still in flight after a stop is dropped on arrival.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_vld    <= '0;
      pipe_last   <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      pipe_vld[0]  <= ram_en;
      pipe_last[0] <= last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      outstanding <= outstanding + CW'(ram_en) - CW'(pipe_vld[READ_LATENCY-1]);
      if (flush) begin
        rd_ptr     <= wr_ptr;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_last[READ_LATENCY-1], ram_rdata};
  end

endmodule
